// File: rtl/hm_error_logger.sv
// ============================================================================
//  Module   : hm_error_logger
//  Purpose  : Health-monitor error logger. Captures non-zero deadline-unit
//             error reports with guest id and timestamp into a first-word-
//             fall-through record FIFO, keeps saturating per-guest error
//             counters, and raises an interrupt to the hypervisor.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module hm_error_logger #(
   parameter int DEPTH   = 8,
   parameter int TIME_W  = 32,
   parameter int GUEST_W = 3,
   parameter int ERR_W   = 3,
   parameter int CNT_W   = 8
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     enable,
   input  logic                     finish,
   input  logic [ERR_W-1:0]         tdi_error,
   input  logic [GUEST_W-1:0]       current_guest,
   input  logic [TIME_W-1:0]        current_time,
   output logic                     rec_valid,
   input  logic                     rec_ready,
   output logic [TIME_W-1:0]        rec_time,
   output logic [GUEST_W-1:0]       rec_guest,
   output logic [ERR_W-1:0]         rec_code,
   output logic [$clog2(DEPTH):0]   rec_count,
   output logic                     irq,
   input  logic                     irq_ack,
   output logic                     lost,
   input  logic [GUEST_W-1:0]       cnt_sel,
   output logic [CNT_W-1:0]         cnt_value,
   input  logic                     cnt_clear
);

   localparam int AW    = $clog2(DEPTH);
   localparam int CW    = AW + 1;
   localparam int NG    = 1 << GUEST_W;
   localparam int REC_W = TIME_W + GUEST_W + ERR_W;

   typedef enum logic [1:0] {
      IRQ_IDLE = 2'd0,
      IRQ_PEND = 2'd1,
      IRQ_SERV = 2'd2
   } irq_state_t;

   logic [REC_W-1:0] mem_q [DEPTH];
   logic [AW-1:0]    wr_ptr_q;
   logic [AW-1:0]    rd_ptr_q;
   logic [CW-1:0]    count_q;
   logic [CW-1:0]    count_d;
   logic             lost_q;
   logic [CNT_W-1:0] cnt_q [NG];
   irq_state_t       state_q;
   logic             irq_q;

   logic             ev;
   logic             full;
   logic             pop;
   logic             push;
   logic             drop;
   logic [REC_W-1:0] head;

   assign ev   = enable & finish & (tdi_error != '0);
   assign full = (count_q == CW'(DEPTH));
   assign pop  = rec_valid & rec_ready;
   // A push into a full FIFO is still accepted when the head leaves in the same cycle.
   assign push = ev & (~full | pop);
   assign drop = ev & full & ~pop;

   assign rec_valid = (count_q != '0);
   assign head      = mem_q[rd_ptr_q];
   // Outputs read as zero while empty so a reset clears them immediately.
   assign rec_time  = rec_valid ? head[REC_W-1 -: TIME_W]        : '0;
   assign rec_guest = rec_valid ? head[ERR_W +: GUEST_W]         : '0;
   assign rec_code  = rec_valid ? head[ERR_W-1:0]                : '0;
   assign rec_count = count_q;
   assign irq       = irq_q;
   assign lost      = lost_q;
   assign cnt_value = cnt_q[cnt_sel];

   // Next occupancy: simultaneous push and pop leave the count unchanged.
   always_comb begin
      count_d = count_q;
      if (push && !pop) begin
         count_d = count_q + CW'(1);
      end else if (pop && !push) begin
         count_d = count_q - CW'(1);
      end
   end

   // Record storage; contents need no reset because occupancy gates visibility.
   always_ff @(posedge clk) begin
      if (push) begin
         mem_q[wr_ptr_q] <= {current_time, current_guest, tdi_error};
      end
   end

   // FIFO pointers and occupancy; pointers wrap naturally at power-of-two DEPTH.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
         if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
         count_q <= count_d;
      end
   end

   // Sticky overflow flag; a drop in the same cycle as a clear keeps it set.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         lost_q <= 1'b0;
      end else if (drop) begin
         lost_q <= 1'b1;
      end else if (cnt_clear) begin
         lost_q <= 1'b0;
      end
   end

   // Per-guest saturating counters; clear plus increment of one guest yields 1.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int g = 0; g < NG; g++) cnt_q[g] <= '0;
      end else begin
         for (int g = 0; g < NG; g++) begin
            if (cnt_clear && (cnt_sel == GUEST_W'(g))) begin
               cnt_q[g] <= (ev && (current_guest == GUEST_W'(g))) ? CNT_W'(1) : '0;
            end else if (ev && (current_guest == GUEST_W'(g)) && (cnt_q[g] != '1)) begin
               cnt_q[g] <= cnt_q[g] + CNT_W'(1);
            end
         end
      end
   end

   // Interrupt FSM. Leaving IDLE keys off the registered occupancy, so a
   // capture at edge N is seen at edge N+1 and irq rises after that edge.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= IRQ_IDLE;
         irq_q   <= 1'b0;
      end else begin
         case (state_q)
            IRQ_IDLE: begin
               if (count_q != '0) begin
                  state_q <= IRQ_PEND;
                  irq_q   <= 1'b1;
               end
            end
            IRQ_PEND: begin
               if (irq_ack) begin
                  state_q <= IRQ_SERV;
                  irq_q   <= 1'b0;
               end
            end
            IRQ_SERV: begin
               if (push) begin
                  state_q <= IRQ_PEND;
                  irq_q   <= 1'b1;
               end else if (count_d == '0) begin
                  state_q <= IRQ_IDLE;
                  irq_q   <= 1'b0;
               end
            end
            default: begin
               state_q <= IRQ_IDLE;
               irq_q   <= 1'b0;
            end
         endcase
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_hm_error_logger.sv
// ============================================================================
//  Module   : tb_hm_error_logger
//  Purpose  : Directed self-checking bench for hm_error_logger with a record
//             scoreboard queue and behavioural counter/lost model.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_hm_error_logger;

   localparam int DEPTH   = 8;
   localparam int CNT_MAX = 255;

   typedef struct {
      logic [31:0] t;
      logic [2:0]  g;
      logic [2:0]  c;
   } rec_t;

   logic        clk = 1'b0;
   logic        reset;
   logic        enable;
   logic        finish;
   logic [2:0]  tdi_error;
   logic [2:0]  current_guest;
   logic [31:0] current_time;
   logic        rec_valid;
   logic        rec_ready;
   logic [31:0] rec_time;
   logic [2:0]  rec_guest;
   logic [2:0]  rec_code;
   logic [3:0]  rec_count;
   logic        irq;
   logic        irq_ack;
   logic        lost;
   logic [2:0]  cnt_sel;
   logic [7:0]  cnt_value;
   logic        cnt_clear;

   int   checks = 0;
   int   errors = 0;
   rec_t sb[$];
   int   mcnt [8];
   bit   mlost;

   hm_error_logger #(
      .DEPTH(DEPTH), .TIME_W(32), .GUEST_W(3), .ERR_W(3), .CNT_W(8)
   ) dut (
      .clk(clk), .reset(reset), .enable(enable), .finish(finish),
      .tdi_error(tdi_error), .current_guest(current_guest),
      .current_time(current_time), .rec_valid(rec_valid),
      .rec_ready(rec_ready), .rec_time(rec_time), .rec_guest(rec_guest),
      .rec_code(rec_code), .rec_count(rec_count), .irq(irq),
      .irq_ack(irq_ack), .lost(lost), .cnt_sel(cnt_sel),
      .cnt_value(cnt_value), .cnt_clear(cnt_clear)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Update the model from the inputs about to be sampled, then clock once.
   task automatic step();
      bit   e, p, f, drop;
      rec_t h;
      e = enable && finish && (tdi_error != 3'd0);
      f = (sb.size() == DEPTH);
      p = rec_ready && (sb.size() != 0);
      if (p) begin
         h = sb.pop_front();
         chk("pop_time",  rec_time,  h.t);
         chk("pop_guest", rec_guest, h.g);
         chk("pop_code",  rec_code,  h.c);
      end
      drop = e && f && !p;
      if (e && !drop) sb.push_back('{current_time, current_guest, tdi_error});
      for (int g = 0; g < 8; g++) begin
         if (cnt_clear && (cnt_sel == g))
            mcnt[g] = (e && (current_guest == g)) ? 1 : 0;
         else if (e && (current_guest == g) && (mcnt[g] < CNT_MAX))
            mcnt[g]++;
      end
      mlost = drop ? 1'b1 : (cnt_clear ? 1'b0 : mlost);
      @(posedge clk);
      #1;
      chk("rec_count", rec_count, sb.size());
      chk("rec_valid", rec_valid, sb.size() != 0);
      chk("lost",      lost,      mlost);
      chk("cnt_value", cnt_value, mcnt[cnt_sel]);
   endtask

   task automatic set_ev(input logic [2:0] g, input logic [2:0] c, input logic [31:0] t);
      finish = 1'b1; current_guest = g; tdi_error = c; current_time = t;
   endtask

   task automatic no_ev();
      finish = 1'b0; tdi_error = 3'd0;
   endtask

   // Acknowledge, then idle until the FSM has returned to IDLE on an empty FIFO.
   task automatic ack_and_settle();
      irq_ack = 1'b1; step(); irq_ack = 1'b0;
      step(); step();
      chk("settle_irq", irq, 1'b0);
   endtask

   initial begin
      reset = 1'b0; enable = 1'b1; finish = 1'b0; tdi_error = 3'd0;
      current_guest = 3'd0; current_time = 32'd0; rec_ready = 1'b0;
      irq_ack = 1'b0; cnt_sel = 3'd0; cnt_clear = 1'b0;
      for (int g = 0; g < 8; g++) mcnt[g] = 0;
      mlost = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_valid", rec_valid, 1'b0);
      chk("rst_count", rec_count, 4'd0);
      chk("rst_irq",   irq,       1'b0);
      chk("rst_lost",  lost,      1'b0);
      chk("rst_time",  rec_time,  32'd0);
      chk("rst_cnt",   cnt_value, 8'd0);
      reset = 1'b1;
      step();

      // 1. single error
      cnt_sel = 3'd1;
      set_ev(3'd1, 3'b010, 32'd100);
      step();
      no_ev();
      chk("t1_time",  rec_time,  32'd100);
      chk("t1_guest", rec_guest, 3'd1);
      chk("t1_code",  rec_code,  3'd2);
      chk("t1_irq_early", irq, 1'b0);
      step();
      chk("t1_irq", irq, 1'b1);
      chk("t1_cnt", cnt_value, 8'd1);
      rec_ready = 1'b1; step(); rec_ready = 1'b0;
      ack_and_settle();

      // 2. fill beyond depth, then drain in order
      cnt_sel = 3'd2;
      for (int i = 0; i < DEPTH + 2; i++) begin
         set_ev(3'd2, 3'((i % 7) + 1), 32'(200 + i));
         step();
      end
      no_ev();
      chk("t2_count", rec_count, 4'd8);
      chk("t2_lost",  lost,      1'b1);
      chk("t2_cnt",   cnt_value, 8'd10);
      rec_ready = 1'b1;
      repeat (DEPTH) step();
      rec_ready = 1'b0;
      chk("t2_irq_pend", irq, 1'b1);
      ack_and_settle();
      cnt_clear = 1'b1; step(); cnt_clear = 1'b0;
      chk("t2_lost_clr", lost, 1'b0);

      // 3. full FIFO with simultaneous push and pop across pointer wrap
      cnt_sel = 3'd3;
      for (int i = 0; i < DEPTH; i++) begin
         set_ev(3'd3, 3'd5, 32'(300 + i));
         step();
      end
      rec_ready = 1'b1;
      for (int i = 0; i < 5; i++) begin
         set_ev(3'd3, 3'd6, 32'(400 + i));
         step();
      end
      no_ev();
      chk("t3_count", rec_count, 4'd8);
      chk("t3_lost",  lost,      1'b0);
      repeat (DEPTH) step();
      rec_ready = 1'b0;
      ack_and_settle();

      // 4. interrupt handshake
      cnt_sel = 3'd4;
      set_ev(3'd4, 3'd1, 32'd500); step(); no_ev();
      step();
      chk("t4_pend", irq, 1'b1);
      irq_ack = 1'b1; step(); irq_ack = 1'b0;
      chk("t4_serv", irq, 1'b0);
      set_ev(3'd4, 3'd3, 32'd501); step(); no_ev();
      chk("t4_repend", irq, 1'b1);
      irq_ack = 1'b1; step(); irq_ack = 1'b0;
      chk("t4_serv2", irq, 1'b0);
      rec_ready = 1'b1; step(); step(); rec_ready = 1'b0;
      step();
      chk("t4_idle", irq, 1'b0);
      irq_ack = 1'b1; step(); irq_ack = 1'b0;
      step();
      chk("t4_stray", irq, 1'b0);
      set_ev(3'd4, 3'd7, 32'd502); step(); no_ev();
      chk("t4_idle_lat", irq, 1'b0);
      step();
      chk("t4_idle_pend", irq, 1'b1);
      rec_ready = 1'b1; step(); rec_ready = 1'b0;
      ack_and_settle();

      // 5. counter saturation and same-cycle clear with increment
      cnt_sel = 3'd5;
      rec_ready = 1'b1;
      for (int i = 0; i < CNT_MAX + 4; i++) begin
         set_ev(3'd5, 3'd4, 32'(1000 + i));
         step();
      end
      chk("t5_sat", cnt_value, 8'd255);
      cnt_clear = 1'b1; step(); cnt_clear = 1'b0;
      no_ev();
      chk("t5_clr_inc", cnt_value, 8'd1);
      step();
      rec_ready = 1'b0;
      ack_and_settle();

      // 6. capture disabled, then asynchronous reset mid-drain
      cnt_sel = 3'd6;
      enable = 1'b0;
      set_ev(3'd6, 3'd5, 32'd2000);
      repeat (3) step();
      chk("t6_dis_cnt",   cnt_value, 8'd0);
      chk("t6_dis_count", rec_count, 4'd0);
      enable = 1'b1;
      for (int i = 0; i < 3; i++) begin
         set_ev(3'd6, 3'd2, 32'(2100 + i));
         step();
      end
      no_ev();
      step();
      chk("t6_irq", irq, 1'b1);
      rec_ready = 1'b1; step();
      #2 reset = 1'b0;
      #1;
      chk("t6_rst_valid", rec_valid, 1'b0);
      chk("t6_rst_count", rec_count, 4'd0);
      chk("t6_rst_time",  rec_time,  32'd0);
      chk("t6_rst_irq",   irq,       1'b0);
      chk("t6_rst_cnt",   cnt_value, 8'd0);
      sb.delete();
      for (int g = 0; g < 8; g++) mcnt[g] = 0;
      mlost = 1'b0;
      #2 reset = 1'b1;
      rec_ready = 1'b0;
      step(); step();
      chk("t6_post_irq", irq, 1'b0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

`default_nettype wire
